// File: rtl/lp805x_sfrfifo.sv
// SFR-mapped 4-entry transmit FIFO for the lp805x core.
// Core pushes bytes through DATA_ADDR; a downstream block drains them over valid/ready.
module lp805x_sfrfifo #(
  parameter logic [7:0] DATA_ADDR = 8'hE9,
  parameter logic [7:0] STAT_ADDR = 8'hE8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] sfr_bus,
  input  logic        load,
  output logic [8:0]  sfr_ret,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);

  typedef struct packed {
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic [7:0] data_in;
    logic       wr;
    logic       rd;
    logic       bit_in;
    logic       wr_bit;
    logic       rd_bit;
  } sfr_req_t;

  sfr_req_t   req;
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count, count_nxt;
  logic       ovf, ie;
  logic       full, empty, pop, push_req, accept;
  logic       stat_byte_wr, stat_bit_wr, flush, ovf_clr, ie_wr, ie_val;
  logic [7:0] status, data_out;
  logic       bit_out;

  assign req   = sfr_req_t'(sfr_bus);
  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr];
  assign irq       = ie & empty;
  assign status    = {1'b0, ovf, ie, count, full, empty};

  assign pop      = out_valid & out_ready;
  assign push_req = load & req.wr & !req.wr_bit & (req.wr_addr == DATA_ADDR);
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign accept   = push_req & (!full | pop);

  assign stat_byte_wr = load & req.wr & !req.wr_bit & (req.wr_addr == STAT_ADDR);
  assign stat_bit_wr  = load & req.wr_bit & (req.wr_addr[7:3] == STAT_ADDR[7:3]);

  always_comb begin
    flush   = 1'b0;
    ovf_clr = 1'b0;
    ie_wr   = 1'b0;
    ie_val  = 1'b0;
    if (stat_byte_wr) begin
      flush   = req.data_in[7];
      ovf_clr = !req.data_in[6];
      ie_wr   = 1'b1;
      ie_val  = req.data_in[5];
    end else if (stat_bit_wr) begin
      flush   = (req.wr_addr[2:0] == 3'd7) &  req.bit_in;
      ovf_clr = (req.wr_addr[2:0] == 3'd6) & !req.bit_in;
      ie_wr   = (req.wr_addr[2:0] == 3'd5);
      ie_val  = req.bit_in;
    end
  end

  always_comb begin
    count_nxt = count + {2'b00, accept} - {2'b00, pop};
    if (flush) count_nxt = 3'd0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= req.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
      ie     <= 1'b0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (pop)    rd_ptr <= rd_ptr + 2'd1;
        if (accept) wr_ptr <= wr_ptr + 2'd1;
      end
      if (push_req && !accept) ovf <= 1'b1;
      else if (ovf_clr)        ovf <= 1'b0;
      if (ie_wr) ie <= ie_val;
    end
  end

  // Non-matching reads return zero so several peripherals can be OR-combined.
  always_comb begin
    data_out = 8'h00;
    bit_out  = 1'b0;
    if (req.rd && !req.rd_bit) begin
      if (req.rd_addr == DATA_ADDR)      data_out = out_data;
      else if (req.rd_addr == STAT_ADDR) data_out = status;
    end
    if (req.rd_bit && (req.rd_addr[7:3] == STAT_ADDR[7:3]))
      bit_out = status[req.rd_addr[2:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sfr_ret <= 9'h000;
    else if (load) sfr_ret <= {data_out, bit_out};
  end

endmodule

// File: tb/tb_lp805x_sfrfifo.sv
// Directed bench for lp805x_sfrfifo: SFR push/read, drain, overflow, irq, flush, reset.
module tb_lp805x_sfrfifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] sfr_bus;
  logic        load;
  logic [8:0]  sfr_ret;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [7:0] DA = 8'hE9;
  localparam logic [7:0] SA = 8'hE8;

  lp805x_sfrfifo dut (
    .clk(clk), .rst(rst), .sfr_bus(sfr_bus), .load(load), .sfr_ret(sfr_ret),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] mk(input logic [7:0] wa, input logic [7:0] ra,
                                     input logic [7:0] din, input logic wr, input logic rd,
                                     input logic bi, input logic wb, input logic rb);
    return {wa, ra, din, wr, rd, bi, wb, rb};
  endfunction

  // One load strobe; returns at the following negedge with results visible.
  task automatic do_op(input logic [28:0] b);
    @(negedge clk);
    sfr_bus = b;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    sfr_bus = '0;
  endtask

  task automatic push(input logic [7:0] b);
    do_op(mk(DA, 8'h00, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic rd_byte(input logic [7:0] a);
    do_op(mk(8'h00, a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic stat_wr(input logic [7:0] v);
    do_op(mk(SA, 8'h00, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic bit_wr(input logic [2:0] idx, input logic v);
    do_op(mk(SA | {5'b0, idx}, 8'h00, 8'h00, 1'b0, 1'b0, v, 1'b1, 1'b0));
  endtask

  task automatic bit_rd(input logic [2:0] idx);
    do_op(mk(8'h00, SA | {5'b0, idx}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  logic [7:0] exp_seq [4];

  initial begin
    rst = 1'b1; load = 1'b0; sfr_bus = '0; out_ready = 1'b0;
    #12;
    check("rst_ret",   32'(sfr_ret),   32'h000);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_irq",   32'(irq),       32'h0);
    @(negedge clk); rst = 1'b0;

    rd_byte(SA);
    check("stat_reset", 32'(sfr_ret), 32'h002);

    // Fill, then overflow
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("full_valid", 32'(out_valid), 32'h1);
    check("full_head",  32'(out_data),  32'h11);
    rd_byte(SA);
    check("stat_full_ovf", 32'(sfr_ret[8:1]), 32'h52);
    rd_byte(DA);
    check("peek_head", 32'(sfr_ret[8:1]), 32'h11);
    check("peek_nopop", 32'(out_data), 32'h11);
    repeat (3) @(negedge clk);
    check("ret_hold", 32'(sfr_ret[8:1]), 32'h11);

    // Drain
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 32'(out_data), 32'(exp_seq[i]));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'h0);

    // Clear ovf with a byte write
    stat_wr(8'h00);
    rd_byte(SA);
    check("stat_ovf_clr", 32'(sfr_ret[8:1]), 32'h01);

    // Push into full FIFO with simultaneous pop
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    @(negedge clk);
    sfr_bus = mk(DA, 8'h00, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0; out_ready = 1'b0; sfr_bus = '0;
    rd_byte(SA);
    check("stat_push_pop", 32'(sfr_ret[8:1]), 32'h12);
    exp_seq = '{8'hBB, 8'hCC, 8'hDD, 8'h66};
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain2_%0d", i), 32'(out_data), 32'(exp_seq[i]));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain2_empty", 32'(out_valid), 32'h0);

    // Interrupt enable via bit write
    check("irq_off", 32'(irq), 32'h0);
    bit_wr(3'd5, 1'b1);
    check("irq_on", 32'(irq), 32'h1);
    bit_rd(3'd0);
    check("bitrd_empty", 32'(sfr_ret), 32'h001);
    bit_rd(3'd7);
    check("bitrd_flush0", 32'(sfr_ret), 32'h000);
    do_op(mk(8'h00, 8'hD0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    check("rd_other", 32'(sfr_ret), 32'h000);

    // Overflow with ie set, then clear ovf by bit write
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
    check("irq_nonempty", 32'(irq), 32'h0);
    rd_byte(SA);
    check("stat_ovf_ie", 32'(sfr_ret[8:1]), 32'h72);
    bit_wr(3'd6, 1'b1);
    rd_byte(SA);
    check("ovf_wr1_nop", 32'(sfr_ret[8:1]), 32'h72);
    bit_wr(3'd6, 1'b0);
    rd_byte(SA);
    check("ovf_bit_clr", 32'(sfr_ret[8:1]), 32'h32);
    bit_wr(3'd7, 1'b1);
    check("bitflush_empty", 32'(out_valid), 32'h0);
    check("bitflush_irq", 32'(irq), 32'h1);

    // Byte-write flush
    push(8'h77); push(8'h88);
    check("pre_flush_head", 32'(out_data), 32'h77);
    stat_wr(8'h80);
    check("flush_valid", 32'(out_valid), 32'h0);
    rd_byte(SA);
    check("flush_stat", 32'(sfr_ret[8:1]), 32'h01);
    rd_byte(DA);
    check("flush_data", 32'(sfr_ret[8:1]), 32'h00);
    push(8'h99);
    check("post_flush_head", 32'(out_data), 32'h99);

    // Asynchronous reset mid-transfer
    push(8'hA5);
    #2 rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_ret",   32'(sfr_ret),   32'h000);
    @(negedge clk); rst = 1'b0;
    rd_byte(SA);
    check("post_rst_stat", 32'(sfr_ret[8:1]), 32'h01);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/lp805x_sfrfifo.md
# lp805x_sfrfifo

SFR-mapped 4-entry transmit FIFO peripheral for the lp805x core. It consumes the packed 29-bit SFR request bus and returns the packed 9-bit response bus ({data_out, bit_out}). Bytes written by the core are queued and drained by a downstream peripheral through a valid/ready port. One SFR transaction is executed per `load` strobe, matching the multi-frequency bus pacing.

## Interface
- DATA_ADDR, 8'hE9: SFR byte address of the data register.
- STAT_ADDR, 8'hE8: SFR byte address of the status/control register. Must be bit-addressable (`[2:0]==0`).

- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- sfr_bus  in  29  request bus, fields by bit range:
  - [28:21] wr_addr
  - [20:13] rd_addr
  - [12:5] data_in
  - [4] wr
  - [3] rd
  - [2] bit_in
  - [1] wr_bit
  - [0] rd_bit
- load  in  1  request-bus qualifier; SFR accesses act only when 1
- sfr_ret  out  9  registered response: [8:1] data_out, [0] bit_out
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts head
- irq  out  1  level interrupt, = ie & empty

## Operation
- Storage: 4×8 array, 2-bit rd/wr pointers (wrap 3→0), 3-bit count 0..4. full = (count==4), empty = (count==0).
- Pop: every clk with out_valid & out_ready, independent of `load`; advances rd pointer.
- Push: on `load` & wr & !wr_bit & wr_addr==DATA_ADDR.
  - Accepted if !full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and ovf is set.
  - Push and pop in the same cycle leave count unchanged.
- STAT register fields:
  - [7] flush: write-only, reads 0. Writing 1 clears pointers and count.
  - [6] ovf: sticky. Writing 0 clears it; writing 1 has no effect.
  - [5] ie: read/write.
  - [4:2] count.
  - [1] full.
  - [0] empty.
  - Writes to [4:0] are ignored.
- STAT byte write: `load` & wr & !wr_bit & wr_addr==STAT_ADDR.
- STAT bit write: `load` & wr_bit & wr_addr[7:3]==STAT_ADDR[7:3]. Bit index wr_addr[2:0], value bit_in; same field rules as a byte write.
- Flush vs pop in the same cycle: the downstream transfer completes, and the FIFO ends empty. ovf is unaffected by flush.
- Byte read (`load` & rd & !rd_bit):
  - rd_addr==DATA_ADDR: data_out = head byte (peek, no pop), or 8'h00 if empty.
  - rd_addr==STAT_ADDR: data_out = status byte.
  - Any other address: data_out = 8'h00, so responses can be OR-combined.
- Bit read (`load` & rd_bit & rd_addr[7:3]==STAT_ADDR[7:3]): bit_out = status[rd_addr[2:0]]. Otherwise bit_out = 0.
- Response values reflect state before any write or pop in the same cycle.

## Timing
- Reset (asynchronous): pointers, count, ovf and ie cleared; sfr_ret=9'h000, out_valid=0, out_data=8'h00, irq=0 (ie=0).
- sfr_ret updates only on `load` clk edges. With no read match on a `load` edge it is written to 0. It holds between `load` strobes.
- Push latency: out_valid rises 1 clk after the accepting `load` edge into an empty FIFO. out_data is valid in the same cycle.
- Pop: the head advances on the out_ready edge; the next byte is presented in the following cycle.
- Status and irq are registered-state derived and update the clk after the event.
- Reset mid-transfer discards all contents; out_valid drops immediately.

## Test plan
- Reset, then load read STAT_ADDR -> sfr_ret = {8'h01,0} (empty=1). irq=0.
- With out_ready=0, push 11,22,33,44, then push 55 -> count=4, full=1, ovf=1. Read STAT = 8'h52. 55 is never output.
- Set out_ready=1 -> out_data sequence 11,22,33,44 over 4 clks. out_valid=0 afterwards.
- FIFO full, push 66 with out_ready=1 in the same cycle -> push accepted, count stays 4. 66 is output last.
- Bit write STAT.5=1 with the FIFO empty -> irq=1 next clk. Bit read rd_addr=E8|0 -> bit_out=1. Bit write STAT.6=0 clears ovf.
- Push 2 bytes, then byte write STAT=8'h80 -> count=0, empty=1, out_valid=0. A read of DATA_ADDR returns 8'h00.
